force_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the per-element force/release override stage. It accepts force, release and release-all commands over a valid/ready handshake, and holds a per-element force-enable and force-value register bank. That bank drives the override muxes of an N-element signal array. After every change it inserts a programmable settle window, so the downstream mux/latch stage never sees back-to-back override updates.

---
 rtl/force_cmd_seq.sv | 128 ++++++++++++
 tb/tb_force_cmd_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/force_cmd_seq.sv
// Force/release command sequencer: owns the per-element force-enable/value bank
// and inserts a settle window after every applied command.
module force_cmd_seq #(
  parameter int N          = 8,
  parameter int W          = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [5:0]     cmd_idx,
  input  logic [W-1:0]   cmd_val,
  output logic [N-1:0]   force_en,
  output logic [N*W-1:0] force_val,
  output logic [6:0]     force_cnt,
  output logic           busy,
  output logic           err
);
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(N);

  // Opcode 2'b00 is NOP: it is accepted and simply falls through every decode below.
  localparam logic [1:0] OP_FORCE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_REL_ALL = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, SETTLE = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   en_reg, en_next;
  logic [N-1:0]   set_vec, clr_vec;
  logic [N*W-1:0] val_reg, val_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [PW-1:0]  ptr_reg;
  logic [3:0]     settle_reg;
  logic           err_reg;
  logic           accept, idx_ok, do_force, do_release, do_rel_all, bad_cmd;
  logic           sweep_last, cnt_inc, cnt_dec;

  assign accept     = cmd_valid & cmd_ready;
  assign idx_ok     = ({1'b0, cmd_idx} < 7'(N));
  assign do_force   = accept && (cmd_op == OP_FORCE) && idx_ok;
  assign do_release = accept && (cmd_op == OP_RELEASE) && idx_ok;
  assign do_rel_all = accept && (cmd_op == OP_REL_ALL);
  assign bad_cmd    = accept && ((cmd_op == OP_FORCE) || (cmd_op == OP_RELEASE)) && !idx_ok;
  assign sweep_last = (ptr_reg == PW'(N - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      assign set_vec[gi] = do_force && (cmd_idx == 6'(gi));
      assign clr_vec[gi] = (do_release && (cmd_idx == 6'(gi))) ||
                           ((state_reg == SWEEP) && (ptr_reg == PW'(gi)));
      assign en_next[gi] = set_vec[gi] | (en_reg[gi] & ~clr_vec[gi]);
      // A release keeps the last forced value so a later re-force starts from it.
      assign val_next[gi*W +: W] = set_vec[gi] ? cmd_val : val_reg[gi*W +: W];
    end
  endgenerate

  // At most one element changes per cycle, so the count moves by at most one.
  assign cnt_inc  = |(set_vec & ~en_reg);
  assign cnt_dec  = |(clr_vec & en_reg);
  assign cnt_next = cnt_reg + CW'(cnt_inc) - CW'(cnt_dec);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (do_force || do_release) begin
          state_next = SETTLE;
        end else if (do_rel_all) begin
          state_next = SWEEP;
        end
      end
      SWEEP:   if (sweep_last) state_next = SETTLE;
      SETTLE:  if (settle_reg == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    cmd_ready = (state_reg == IDLE) && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg     <= '0;
      val_reg    <= '0;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      settle_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      en_reg  <= en_next;
      val_reg <= val_next;
      cnt_reg <= cnt_next;
      err_reg <= bad_cmd;
      if (state_reg == SWEEP) begin
        ptr_reg <= ptr_reg + PW'(1);
      end else begin
        ptr_reg <= '0;
      end
      // Load on entry; SETTLE then lasts SETTLE_CYC+1 cycles.
      if ((state_next == SETTLE) && (state_reg != SETTLE)) begin
        settle_reg <= 4'(SETTLE_CYC);
      end else if ((state_reg == SETTLE) && (settle_reg != 4'd0)) begin
        settle_reg <= settle_reg - 4'd1;
      end
    end
  end

  assign force_en  = en_reg;
  assign force_val = val_reg;
  assign force_cnt = 7'(cnt_reg);
  assign err       = err_reg;

endmodule

// File: tb/tb_force_cmd_seq.sv
// Directed bench for force_cmd_seq: instance a (N=8, SETTLE_CYC=2) and
// instance b (N=6, SETTLE_CYC=0) share clock and reset.
module tb_force_cmd_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_valid, a_ready, a_cval, a_busy, a_err;
  logic [1:0] a_op;
  logic [5:0] a_idx;
  logic [7:0] a_en, a_fval;
  logic [6:0] a_cnt;
  logic       b_valid, b_ready, b_cval, b_busy, b_err;
  logic [1:0] b_op;
  logic [5:0] b_idx;
  logic [5:0] b_en, b_fval;
  logic [6:0] b_cnt;

  int errors = 0;
  int checks = 0;

  force_cmd_seq #(.N(8), .W(1), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_idx(a_idx), .cmd_val(a_cval), .force_en(a_en),
    .force_val(a_fval), .force_cnt(a_cnt), .busy(a_busy), .err(a_err)
  );

  force_cmd_seq #(.N(6), .W(1), .SETTLE_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_idx(b_idx), .cmd_val(b_cval), .force_en(b_en),
    .force_val(b_fval), .force_cnt(b_cnt), .busy(b_busy), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [1:0] op, input logic [5:0] idx, input logic v);
    $display("a cmd op=%0d idx=%0d val=%0d", op, idx, v);
    a_valid = 1'b1; a_op = op; a_idx = idx; a_cval = v;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] op, input logic [5:0] idx, input logic v);
    $display("b cmd op=%0d idx=%0d val=%0d", op, idx, v);
    b_valid = 1'b1; b_op = op; b_idx = idx; b_cval = v;
    tick();
    b_valid = 1'b0;
  endtask

  // Counts remaining busy cycles, bounded so a stuck FSM cannot hang the run.
  task automatic wait_idle_a(output int n);
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin tick(); n++; end
  endtask

  task automatic wait_idle_b(output int n);
    n = 0;
    while (b_busy === 1'b1 && n < 50) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_op = 2'b00; a_idx = '0; a_cval = 1'b0;
    b_valid = 1'b0; b_op = 2'b00; b_idx = '0; b_cval = 1'b0;
    repeat (3) tick();
    checks++; if (a_en !== 8'h00 || a_fval !== 8'h00) begin errors++; $display("FAIL reset_bank: en=%h val=%h want 00/00", a_en, a_fval); end
    checks++; if (a_cnt !== 7'd0 || a_busy !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_flags: cnt=%0d busy=%b err=%b want 0/0/0", a_cnt, a_busy, a_err); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: a=%b b=%b want 0", a_ready, b_ready); end
    checks++; if (b_en !== 6'h00 || b_cnt !== 7'd0) begin errors++; $display("FAIL reset_b: en=%h cnt=%0d want 0", b_en, b_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: a=%b b=%b want 1", a_ready, b_ready); end
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_single_force();
    int n, low;
    issue_a(2'b01, 6'd3, 1'b1);
    checks++; if (a_en !== 8'h08) begin errors++; $display("FAIL sf_en: got %h want 08", a_en); end
    checks++; if (a_fval !== 8'h08) begin errors++; $display("FAIL sf_val: got %h want 08", a_fval); end
    checks++; if (a_cnt !== 7'd1) begin errors++; $display("FAIL sf_cnt: got %0d want 1", a_cnt); end
    n = 0; low = 0;
    while (a_busy === 1'b1 && n < 50) begin
      if (a_ready === 1'b0) low++;
      tick(); n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL sf_busy_cycles: got %0d want 3", n); end
    checks++; if (low !== 3) begin errors++; $display("FAIL sf_ready_low_cycles: got %0d want 3", low); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL sf_ready_back: got %b want 1", a_ready); end
  endtask

  task automatic test_overwrite_release();
    int n;
    issue_a(2'b01, 6'd3, 1'b1); wait_idle_a(n);
    checks++; if (a_cnt !== 7'd1 || a_fval !== 8'h08) begin errors++; $display("FAIL ow1: cnt=%0d val=%h want 1/08", a_cnt, a_fval); end
    issue_a(2'b01, 6'd3, 1'b0); wait_idle_a(n);
    checks++; if (a_cnt !== 7'd1 || a_en !== 8'h08 || a_fval !== 8'h00) begin errors++; $display("FAIL ow2: cnt=%0d en=%h val=%h want 1/08/00", a_cnt, a_en, a_fval); end
    issue_a(2'b10, 6'd3, 1'b0); wait_idle_a(n);
    checks++; if (a_cnt !== 7'd0 || a_en !== 8'h00) begin errors++; $display("FAIL rel1: cnt=%0d en=%h want 0/00", a_cnt, a_en); end
    issue_a(2'b10, 6'd3, 1'b0); wait_idle_a(n);
    checks++; if (a_cnt !== 7'd0 || a_en !== 8'h00 || a_fval !== 8'h00) begin errors++; $display("FAIL rel2: cnt=%0d en=%h val=%h want 0/00/00", a_cnt, a_en, a_fval); end
    checks++; if (n !== 3) begin errors++; $display("FAIL rel_noop_settle: got %0d busy cycles want 3", n); end
    issue_a(2'b01, 6'd2, 1'b1); wait_idle_a(n);
    issue_a(2'b10, 6'd2, 1'b0); wait_idle_a(n);
    checks++; if (a_en !== 8'h00 || a_fval !== 8'h04 || a_cnt !== 7'd0) begin errors++; $display("FAIL rel_retain: en=%h val=%h cnt=%0d want 00/04/0", a_en, a_fval, a_cnt); end
  endtask

  task automatic test_release_all();
    int n;
    logic [7:0] exp_en;
    issue_a(2'b01, 6'd0, 1'b1); wait_idle_a(n);
    issue_a(2'b01, 6'd5, 1'b1); wait_idle_a(n);
    issue_a(2'b01, 6'd7, 1'b1); wait_idle_a(n);
    checks++; if (a_en !== 8'hA1 || a_cnt !== 7'd3) begin errors++; $display("FAIL ra_pre: en=%h cnt=%0d want A1/3", a_en, a_cnt); end
    issue_a(2'b11, 6'd0, 1'b0);
    checks++; if (a_en !== 8'hA1 || a_busy !== 1'b1) begin errors++; $display("FAIL ra_start: en=%h busy=%b want A1/1", a_en, a_busy); end
    exp_en = 8'hA1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_en[i] = 1'b0;
      checks++; if (a_en !== exp_en) begin errors++; $display("FAIL ra_en[%0d]: got %h want %h", i, a_en, exp_en); end
      checks++; if (a_cnt !== 7'($countones(exp_en))) begin errors++; $display("FAIL ra_cnt[%0d]: got %0d want %0d", i, a_cnt, $countones(exp_en)); end
    end
    wait_idle_a(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL ra_settle: got %0d cycles want 3", n); end
  endtask

  task automatic test_bad_index();
    int n;
    issue_b(2'b01, 6'd2, 1'b1);
    wait_idle_b(n);
    checks++; if (n !== 1 || b_en !== 6'h04) begin errors++; $display("FAIL b_settle0: cycles=%0d en=%h want 1/04", n, b_en); end
    b_valid = 1'b1; b_op = 2'b01; b_idx = 6'd6; b_cval = 1'b1;
    tick();
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", b_err); end
    checks++; if (b_en !== 6'h04 || b_cnt !== 7'd1 || b_fval !== 6'h04) begin errors++; $display("FAIL bad_nochange: en=%h cnt=%0d val=%h want 04/1/04", b_en, b_cnt, b_fval); end
    checks++; if (b_ready !== 1'b1 || b_busy !== 1'b0) begin errors++; $display("FAIL bad_ready: ready=%b busy=%b want 1/0", b_ready, b_busy); end
    b_idx = 6'd5;
    tick();
    b_valid = 1'b0;
    checks++; if (b_en !== 6'h24 || b_cnt !== 7'd2 || b_err !== 1'b0) begin errors++; $display("FAIL bad_follow: en=%h cnt=%0d err=%b want 24/2/0", b_en, b_cnt, b_err); end
    wait_idle_b(n);
    b_valid = 1'b1; b_op = 2'b10; b_idx = 6'd63;
    tick();
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL bad_b2b_1: got %b want 1", b_err); end
    tick();
    b_valid = 1'b0;
    checks++; if (b_err !== 1'b1 || b_en !== 6'h24) begin errors++; $display("FAIL bad_b2b_2: err=%b en=%h want 1/24", b_err, b_en); end
    tick();
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL bad_err_drop: got %b want 0", b_err); end
  endtask

  task automatic test_nop();
    issue_a(2'b00, 6'd3, 1'b1);
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_en !== 8'h00 || a_err !== 1'b0) begin errors++; $display("FAIL nop: busy=%b ready=%b en=%h err=%b want 0/1/00/0", a_busy, a_ready, a_en, a_err); end
  endtask

  task automatic test_back_to_back();
    int nacc, last, n;
    nacc = 0; last = -1;
    a_valid = 1'b1; a_op = 2'b01; a_idx = 6'd1; a_cval = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (a_ready === 1'b1) begin nacc++; last = i; end
      tick();
    end
    a_valid = 1'b0;
    $display("a held-valid FORCE idx=1: %0d accepts, last at cycle %0d", nacc, last);
    checks++; if (nacc !== 3 || last !== 8) begin errors++; $display("FAIL b2b_spacing: accepts=%0d last=%0d want 3/8", nacc, last); end
    wait_idle_a(n);
    checks++; if (a_en !== 8'h02 || a_cnt !== 7'd1) begin errors++; $display("FAIL b2b_state: en=%h cnt=%0d want 02/1", a_en, a_cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    issue_a(2'b01, 6'd2, 1'b1); wait_idle_a(n);
    issue_a(2'b01, 6'd4, 1'b1); wait_idle_a(n);
    issue_a(2'b01, 6'd6, 1'b0); wait_idle_a(n);
    checks++; if (a_en !== 8'h56 || a_cnt !== 7'd4) begin errors++; $display("FAIL rms_pre: en=%h cnt=%0d want 56/4", a_en, a_cnt); end
    issue_a(2'b11, 6'd0, 1'b0);
    tick();
    checks++; if (a_en !== 8'h56 || a_busy !== 1'b1) begin errors++; $display("FAIL rms_sweep: en=%h busy=%b want 56/1", a_en, a_busy); end
    rst_n = 1'b0;
    a_valid = 1'b1; a_op = 2'b01; a_idx = 6'd3; a_cval = 1'b1;
    tick();
    checks++; if (a_en !== 8'h00 || a_cnt !== 7'd0 || a_fval !== 8'h00) begin errors++; $display("FAIL rms_clear: en=%h cnt=%0d val=%h want 00/0/00", a_en, a_cnt, a_fval); end
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL rms_flags: busy=%b ready=%b err=%b want 0/0/0", a_busy, a_ready, a_err); end
    tick();
    checks++; if (a_en !== 8'h00) begin errors++; $display("FAIL rms_no_accept: en=%h want 00", a_en); end
    a_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rms_ready: got %b want 1", a_ready); end
    tick();
    checks++; if (a_busy !== 1'b0 || a_en !== 8'h00) begin errors++; $display("FAIL rms_idle: busy=%b en=%h want 0/00", a_busy, a_en); end
  endtask

  initial begin
    test_reset();
    test_single_force();
    test_overwrite_release();
    test_release_all();
    test_bad_index();
    test_nop();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
